p4_router_dq_scheduler: RTL and testbench

- Egress dequeue scheduler for the P4 router queue system.
- Each egress port has NUM_QUEUES_PER_EGR_PORT queues.
- Picks one (egress_port, queue) per grant: round-robin across ports, strict priority within a port.
- Issues the dequeue request to queue states / egress buffer and enforces the DQ_LATENCY per-port holdoff between dequeues.

---
 rtl/p4_router_pkg.sv | 20 ++
 rtl/p4_router_rr_arbiter.sv | 35 +++
 rtl/p4_router_dq_scheduler.sv | 123 ++++++++++++
 tb/tb_p4_router_dq_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_router_pkg.sv
// Shared P4 router queue-system constants and the dequeue request/scheduler types.
package p4_router_pkg;

  localparam int NUM_QUEUES_PER_EGR_PORT                 = 4;
  localparam int NUM_QUEUES_PER_EGR_PORT_LOG             = 2;
  localparam int DQ_LATENCY                              = 6;
  localparam int EGR_COUNTERS_WIDTH                      = 16;
  localparam int VNP4_WRAPPER_METADATA_EGRESS_PORT_WIDTH = 4;

  typedef struct packed {
    logic [VNP4_WRAPPER_METADATA_EGRESS_PORT_WIDTH-1:0] egress_port;
    logic [NUM_QUEUES_PER_EGR_PORT_LOG-1:0]             queue;
  } dq_req_t;

  typedef enum logic {
    SELECT = 1'b0,
    REQ    = 1'b1
  } dq_sched_state_t;

endpackage

// File: rtl/p4_router_rr_arbiter.sv
// N-way round-robin pick: first requester at or after ptr, wrapping at N-1.
// Purely combinational; no backpressure.
module p4_router_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int          c;
    logic [IW-1:0] cidx;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    cidx  = '0;
    for (int i = 0; i < N; i++) begin
      // Explicit wrap keeps non-power-of-2 port counts correct.
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      cidx = IW'(c);
      if (!any && req[cidx]) begin
        any         = 1'b1;
        idx         = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/p4_router_dq_scheduler.sv
// Egress dequeue scheduler: RR across ports, strict priority within a port; valid one cycle after selection, per-port holdoff between grants.
// Request held stable until dq_req_ready; optional grant counters under P4_ROUTER_DQ_SCHED_STATS_EN.
module p4_router_dq_scheduler
  import p4_router_pkg::*;
#(
  parameter int NUM_EGR_PORTS  = 8,
  parameter int NUM_QUEUES     = NUM_QUEUES_PER_EGR_PORT,
  parameter int HOLDOFF_CYCLES = DQ_LATENCY
) (
  input  logic                                               clk,
  input  logic                                               sreset,
  input  logic                                               enable,
  input  logic [NUM_EGR_PORTS*NUM_QUEUES-1:0]                queue_empty,
  input  logic [NUM_EGR_PORTS-1:0]                           egress_ready,
  output logic                                               dq_req_valid,
  input  logic                                               dq_req_ready,
  output logic [VNP4_WRAPPER_METADATA_EGRESS_PORT_WIDTH-1:0] dq_req_port,
  output logic [NUM_QUEUES_PER_EGR_PORT_LOG-1:0]             dq_req_queue
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
  ,
  input  logic                                               stats_clear,
  output logic [NUM_EGR_PORTS*EGR_COUNTERS_WIDTH-1:0]        grant_count
`endif
);

  localparam int PW    = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1;
  localparam int HW    = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int QW    = NUM_QUEUES_PER_EGR_PORT_LOG;
  localparam int PORTW = VNP4_WRAPPER_METADATA_EGRESS_PORT_WIDTH;

  dq_sched_state_t state_q, state_d;
  dq_req_t         req_q;
  logic            load, hs;
  logic [PW-1:0]   rr_ptr, sel_idx;
  logic            sel_any;
  logic [NUM_EGR_PORTS-1:0] elig, sel_grant;
  logic [NUM_QUEUES-1:0]    port_empty [NUM_EGR_PORTS];
  logic [HW-1:0]            holdoff    [NUM_EGR_PORTS];
  logic [QW-1:0]            sel_queue;
  logic [NUM_QUEUES-1:0]    sel_empty;

  for (genvar p = 0; p < NUM_EGR_PORTS; p++) begin : g_elig
    assign port_empty[p] = queue_empty[p*NUM_QUEUES +: NUM_QUEUES];
    assign elig[p]       = enable & egress_ready[p] & (holdoff[p] == '0) & ~(&port_empty[p]);
  end

  p4_router_rr_arbiter #(.N(NUM_EGR_PORTS), .IW(PW)) u_rr (
    .req   (elig),
    .ptr   (rr_ptr),
    .grant (sel_grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    sel_empty = port_empty[sel_idx];
    sel_queue = '0;
    for (int q = NUM_QUEUES-1; q >= 0; q--) begin
      if (!sel_empty[q]) sel_queue = QW'(q);
    end
  end

  assign dq_req_valid = (state_q == REQ);
  assign dq_req_port  = req_q.egress_port;
  assign dq_req_queue = req_q.queue;
  assign hs           = dq_req_valid & dq_req_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      SELECT: if (sel_any) begin
        state_d = REQ;
        load    = 1'b1;
      end
      REQ:    if (dq_req_ready) state_d = SELECT;
      default: state_d = SELECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= SELECT;
      req_q   <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        req_q.egress_port <= PORTW'(sel_idx);
        req_q.queue       <= sel_queue;
      end
      if (hs) begin
        if (req_q.egress_port == PORTW'(NUM_EGR_PORTS-1)) rr_ptr <= '0;
        else                                              rr_ptr <= PW'(req_q.egress_port) + PW'(1);
      end
    end
  end

  // Loaded with HOLDOFF_CYCLES-2 so the earliest reselection lands valid exactly HOLDOFF_CYCLES after the handshake.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      if (sreset)                                          holdoff[p] <= '0;
      else if (hs && req_q.egress_port == PORTW'(p))       holdoff[p] <= HW'(HOLDOFF_CYCLES-2);
      else if (holdoff[p] != '0)                           holdoff[p] <= holdoff[p] - HW'(1);
    end
  end

`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
  logic [EGR_COUNTERS_WIDTH-1:0] cnt [NUM_EGR_PORTS];

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_EGR_PORTS; p++) begin
      if (sreset || stats_clear)                     cnt[p] <= '0;
      else if (hs && req_q.egress_port == PORTW'(p)) cnt[p] <= cnt[p] + EGR_COUNTERS_WIDTH'(1);
    end
  end

  for (genvar p = 0; p < NUM_EGR_PORTS; p++) begin : g_cnt
    assign grant_count[p*EGR_COUNTERS_WIDTH +: EGR_COUNTERS_WIDTH] = cnt[p];
  end
`endif

endmodule

// File: tb/tb_p4_router_dq_scheduler.sv
// Randomized and directed bench for p4_router_dq_scheduler against a timestamp-based grant model.
module tb_p4_router_dq_scheduler;
  import p4_router_pkg::*;

  localparam int NP = 8;
  localparam int NQ = NUM_QUEUES_PER_EGR_PORT;
  localparam int H  = DQ_LATENCY;
  localparam int CW = EGR_COUNTERS_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 sreset = 1'b1, enable = 1'b1, dq_req_ready = 1'b0;
  logic [NP*NQ-1:0]     queue_empty = '1;
  logic [NP-1:0]        egress_ready = '1;
  logic                 dq_req_valid;
  logic [VNP4_WRAPPER_METADATA_EGRESS_PORT_WIDTH-1:0] dq_req_port;
  logic [NUM_QUEUES_PER_EGR_PORT_LOG-1:0]             dq_req_queue;
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
  logic                 stats_clear = 1'b0;
  logic [NP*CW-1:0]     grant_count;
`endif

  p4_router_dq_scheduler #(.NUM_EGR_PORTS(NP), .NUM_QUEUES(NQ), .HOLDOFF_CYCLES(H)) dut (
    .clk          (clk),
    .sreset       (sreset),
    .enable       (enable),
    .queue_empty  (queue_empty),
    .egress_ready (egress_ready),
    .dq_req_valid (dq_req_valid),
    .dq_req_ready (dq_req_ready),
    .dq_req_port  (dq_req_port),
    .dq_req_queue (dq_req_queue)
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
    ,
    .stats_clear  (stats_clear),
    .grant_count  (grant_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: a pending request plus per-port timestamp of last handshake edge.
  int  edge_n = 0;
  bit  m_pend;
  int  m_port, m_queue, m_rr;
  int  m_last [NP];
  int  m_cnt  [NP];
  int  d_port [$];
  int  d_queue[$];
  int  d_edge [$];

  function automatic void m_reset();
    m_pend = 0; m_port = 0; m_queue = 0; m_rr = 0;
    for (int p = 0; p < NP; p++) begin
      m_last[p] = -1000;
      m_cnt[p]  = 0;
    end
  endfunction

  function automatic bit m_elig(input int p);
    logic [NQ-1:0] e;
    e = queue_empty[p*NQ +: NQ];
    return enable && egress_ready[p] && (edge_n - m_last[p] >= H-1) && (e != '1);
  endfunction

  function automatic int first_nonempty(input int p);
    logic [NQ-1:0] e;
    e = queue_empty[p*NQ +: NQ];
    for (int q = 0; q < NQ; q++) if (!e[q]) return q;
    return -1;
  endfunction

  task automatic step();
    bit found;
    if (dq_req_valid && dq_req_ready) begin
      d_port.push_back(int'(dq_req_port));
      d_queue.push_back(int'(dq_req_queue));
      d_edge.push_back(edge_n + 1);
    end
    @(posedge clk);
    edge_n++;
    if (sreset) m_reset();
    else begin
      if (m_pend) begin
        if (dq_req_ready) begin
          m_last[m_port] = edge_n;
          m_rr           = (m_port + 1) % NP;
          m_cnt[m_port]  = (m_cnt[m_port] + 1) % (1 << CW);
          m_pend         = 0;
        end
      end else begin
        found = 0;
        for (int i = 0; i < NP; i++) begin
          int p;
          p = (m_rr + i) % NP;
          if (!found && m_elig(p)) begin
            found   = 1;
            m_pend  = 1;
            m_port  = p;
            m_queue = first_nonempty(p);
          end
        end
      end
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
      if (stats_clear) for (int p = 0; p < NP; p++) m_cnt[p] = 0;
`endif
    end
    #1;
    check("valid", dq_req_valid, m_pend);
    if (m_pend) begin
      check("port", dq_req_port, m_port);
      check("queue", dq_req_queue, m_queue);
    end
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
    for (int p = 0; p < NP; p++) check("grant_count", grant_count[p*CW +: CW], m_cnt[p]);
`endif
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    d_port.delete(); d_queue.delete(); d_edge.delete();
  endtask

  task automatic do_reset();
    sreset = 1'b1; dq_req_ready = 1'b0; enable = 1'b1;
    queue_empty = '1; egress_ready = '1;
    steps(2);
    sreset = 1'b0;
    clear_log();
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n;
    n = 0;
    while (!dq_req_valid && n < max) begin
      step();
      n++;
    end
    check(tag, dq_req_valid, 1);
  endtask

  function automatic int count_port(input int p);
    int c;
    c = 0;
    foreach (d_port[i]) if (d_port[i] == p) c++;
    return c;
  endfunction

  initial begin
    m_reset();
    do_reset();
    check("reset_valid", dq_req_valid, 0);
    check("reset_port", dq_req_port, 0);
    check("reset_queue", dq_req_queue, 0);

    // Idle: nothing queued.
    steps(100);
    check("idle_hs", d_port.size(), 0);
    check("idle_port", dq_req_port, 0);

    // Round robin over ports 0,2,5, queue 1 each.
    do_reset();
    queue_empty[0*NQ+1] = 1'b0;
    queue_empty[2*NQ+1] = 1'b0;
    queue_empty[5*NQ+1] = 1'b0;
    dq_req_ready = 1'b1;
    steps(10);
    check("rr_count", d_port.size() >= 4, 1);
    if (d_port.size() >= 4) begin
      check("rr_p0", d_port[0], 0);
      check("rr_p1", d_port[1], 2);
      check("rr_p2", d_port[2], 5);
      check("rr_p3", d_port[3], 0);
      check("rr_q0", d_queue[0], 1);
      check("rr_q3", d_queue[3], 1);
      for (int k = 0; k < 3; k++) check("rr_spacing", d_edge[k+1] - d_edge[k], 2);
    end

    // Holdoff on a lone port.
    do_reset();
    queue_empty[3*NQ] = 1'b0;
    dq_req_ready = 1'b1;
    steps(3*H + 4);
    check("hold_count", d_port.size() >= 3, 1);
    if (d_port.size() >= 3) begin
      check("hold_gap0", d_edge[1] - d_edge[0], H);
      check("hold_gap1", d_edge[2] - d_edge[1], H);
    end

    // Priority with backpressure: request must not change while stalled.
    do_reset();
    queue_empty[1*NQ+2] = 1'b0;
    queue_empty[1*NQ+3] = 1'b0;
    steps(2);
    queue_empty[1*NQ+0] = 1'b0;
    enable = 1'b0;
    egress_ready = '0;
    steps(20);
    check("bp_valid", dq_req_valid, 1);
    check("bp_port", dq_req_port, 1);
    check("bp_queue", dq_req_queue, 2);
    enable = 1'b1;
    egress_ready = '1;
    dq_req_ready = 1'b1;
    steps(H + 4);
    check("bp_count", d_port.size() >= 2, 1);
    if (d_port.size() >= 2) begin
      check("bp_first_q", d_queue[0], 2);
      check("bp_next_p", d_port[1], 1);
      check("bp_next_q", d_queue[1], 0);
    end

    // Gating by egress_ready and enable.
    do_reset();
    queue_empty[4*NQ] = 1'b0;
    queue_empty[6*NQ] = 1'b0;
    egress_ready[4] = 1'b0;
    dq_req_ready = 1'b1;
    steps(30);
    check("gate_p4_blocked", count_port(4), 0);
    check("gate_p6_served", count_port(6) > 0, 1);
    egress_ready[4] = 1'b1;
    clear_log();
    steps(12);
    check("gate_p4_served", count_port(4) > 0, 1);
    enable = 1'b0;
    steps(2);
    clear_log();
    steps(20);
    check("enable_off_hs", d_port.size(), 0);
    check("enable_off_valid", dq_req_valid, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NP*NQ; b++) queue_empty[b] = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < NP; p++) egress_ready[p] = ($urandom_range(0, 4) != 0);
      enable       = ($urandom_range(0, 9) != 0);
      dq_req_ready = ($urandom_range(0, 4) < 3);
      sreset       = ($urandom_range(0, 299) == 0);
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
      stats_clear  = ($urandom_range(0, 99) == 0);
`endif
      step();
    end
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
    stats_clear = 1'b0;
`endif

    // Seven grants on port 2, then an eighth coincident with clear, then reset mid-request.
    do_reset();
    queue_empty[2*NQ] = 1'b0;
    dq_req_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (d_port.size() < 7 && n < 200) begin
        step();
        n++;
      end
    end
    check("stats_seven", d_port.size(), 7);
    dq_req_ready = 1'b0;
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
    check("stats_cnt7", grant_count[2*CW +: CW], 7);
    wait_valid(20, "stats_wait8");
    stats_clear = 1'b1;
    dq_req_ready = 1'b1;
    step();
    stats_clear = 1'b0;
    dq_req_ready = 1'b0;
    check("stats_clear_wins", grant_count[2*CW +: CW], 0);
`endif
    wait_valid(20, "rst_wait");
    sreset = 1'b1;
    step();
    sreset = 1'b0;
    check("rst_valid", dq_req_valid, 0);
    check("rst_port", dq_req_port, 0);
`ifdef P4_ROUTER_DQ_SCHED_STATS_EN
    check("rst_cnt", grant_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
